unified_mem_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between two requesters: the instruction-fetch stage and the MEM-stage load/store path.
- Each cycle it grants at most one request, drives the memory port, and routes the synchronous read data back to the granted requester.
- It returns a stall to fetch when fetch loses arbitration.
- It bounds fetch starvation with a streak counter and keeps a saturating conflict counter for debug.

---
 rtl/unified_mem_arbiter_if.sv | 45 ++++
 rtl/unified_mem_arbiter.sv | 112 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - request/response and memory-port bundle for unified_mem_arbiter
// Purpose: groups the fetch port, data port, memory port and debug counter.
// Modports: master = requesters and memory (drive requests, mem_rdata),
//           slave  = arbiter (drives grants, responses, memory controls).
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int CNT_W  = 16
);
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [31:0]       if_rdata;
   logic              if_stall;

   logic              d_req;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [31:0]       d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [CNT_W-1:0]  conflict_cnt;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_valid, if_rdata, if_stall,
      input  d_gnt, d_valid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, if_stall,
      output d_gnt, d_valid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - arbiter sharing one single-ported memory between fetch and load/store
// Purpose: grants at most one request per cycle (data first, fetch after a
//          data-win streak of STARVE_LIMIT), drives the memory port and
//          routes the next-cycle read data to the granted requester.
// Ports: clk - rising-edge clock
//        rst - asynchronous active-low reset
//        bus - unified_mem_arbiter_if.slave (fetch, data, memory, conflict_cnt)
module unified_mem_arbiter #(
   parameter int ADDR_W       = 13,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input logic                  clk,
   input logic                  rst,
   unified_mem_arbiter_if.slave bus
);
   localparam int            SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   owner_e           owner_q, owner_d;
   logic             oor_q, oor_d;
   logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
   logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

   logic        if_gnt, d_gnt;
   logic        if_oor, d_oor, sel_oor;
   logic        any_gnt, mem_en, mem_we;
   logic        if_valid, d_valid;
   logic [31:0] sel_addr;
   logic        unused_addr_bits;

   // Byte-lane bits are not used by a word-wide memory.
   assign unused_addr_bits = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

   // Arbitration and address selection.
   always_comb begin
      if_oor   = |bus.if_addr[31:ADDR_W];
      d_oor    = |bus.d_addr[31:ADDR_W];
      // Fetch wins only when data is idle or fetch has lost STARVE_LIMIT times in a row.
      if_gnt   = rst & bus.if_req & (~bus.d_req | (starve_cnt_q == STARVE_MAX));
      d_gnt    = rst & bus.d_req & ~if_gnt;
      any_gnt  = if_gnt | d_gnt;
      sel_addr = d_gnt ? bus.d_addr : bus.if_addr;
      sel_oor  = d_gnt ? d_oor : if_oor;
      // Out-of-range grants are acknowledged but never reach the memory.
      mem_en   = any_gnt & ~sel_oor;
      mem_we   = mem_en & d_gnt & bus.d_we;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q        <= OWN_NONE;
         oor_q          <= 1'b0;
         starve_cnt_q   <= '0;
         conflict_cnt_q <= '0;
      end else begin
         owner_q        <= owner_d;
         oor_q          <= oor_d;
         starve_cnt_q   <= starve_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   // Next state.
   always_comb begin
      owner_d = OWN_NONE;
      if (d_gnt) begin
         owner_d = OWN_D;
      end else if (if_gnt) begin
         owner_d = OWN_IF;
      end
      oor_d = any_gnt & sel_oor;

      starve_cnt_d = starve_cnt_q;
      if (if_gnt || !bus.if_req) begin
         starve_cnt_d = '0;
      end else if (d_gnt && (starve_cnt_q != STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + SW'(1);
      end

      conflict_cnt_d = conflict_cnt_q;
      if (bus.if_req && bus.d_req && !(&conflict_cnt_q)) begin
         conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
      end
   end

   // Outputs.
   always_comb begin
      if_valid      = (owner_q == OWN_IF);
      d_valid       = (owner_q == OWN_D);
      bus.if_gnt    = if_gnt;
      bus.d_gnt     = d_gnt;
      bus.if_stall  = bus.if_req & ~if_gnt;
      bus.mem_en    = mem_en;
      bus.mem_we    = mem_we;
      // Idle port values are forced to zero so they never carry X.
      bus.mem_addr  = mem_en ? sel_addr[ADDR_W-1:2] : '0;
      bus.mem_wdata = mem_we ? bus.d_wdata : '0;
      bus.if_valid  = if_valid;
      bus.d_valid   = d_valid;
      bus.if_rdata  = (if_valid & ~oor_q) ? bus.mem_rdata : '0;
      bus.d_rdata   = (d_valid & ~oor_q) ? bus.mem_rdata : '0;
      bus.conflict_cnt = conflict_cnt_q;
   end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard testbench for unified_mem_arbiter
module tb_unified_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   unified_mem_arbiter_if #(.ADDR_W(13), .CNT_W(16)) bus ();

   unified_mem_arbiter #(.ADDR_W(13), .STARVE_LIMIT(4), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory model: synchronous read, data one cycle after mem_en.
   logic [31:0]   mem [0:2047];
   logic [2047:0] written;
   logic [31:0]   mem_rdata_r;

   function automatic logic [31:0] init_word(input logic [10:0] a);
      case (a)
         11'h000: init_word = 32'h0000_0013;
         11'h001: init_word = 32'h0000_0011;
         11'h002: init_word = 32'h0000_0022;
         11'h010: init_word = 32'h1111_0040;
         11'h040: init_word = 32'hCAFE_0100;
         default: init_word = 32'hA000_0000 | {21'd0, a};
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         written <= '0;
      end else if (bus.mem_en) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
         end
         mem_rdata_r <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr);
      end
   end
   assign bus.mem_rdata = mem_rdata_r;

   // Scoreboard.
   typedef struct {
      logic        chk;
      logic [31:0] data;
   } exp_t;

   exp_t ifq[$];
   exp_t dq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic c, input logic [31:0] d);
      exp_t e;
      e.chk  = c;
      e.data = d;
      return e;
   endfunction

   // Monitor: pops one expectation per valid pulse.
   always @(negedge clk) begin
      exp_t e;
      if (bus.if_valid) begin
         if (ifq.size() == 0) begin
            chk("if_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = ifq.pop_front();
            if (e.chk) chk("if_rdata", bus.if_rdata, e.data);
         end
      end else begin
         chk("if_rdata_idle", bus.if_rdata, 32'd0);
      end
      if (bus.d_valid) begin
         if (dq.size() == 0) begin
            chk("d_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = dq.pop_front();
            if (e.chk) chk("d_rdata", bus.d_rdata, e.data);
         end
      end else begin
         chk("d_rdata_idle", bus.d_rdata, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h0;
      bus.d_wdata = 32'h0;

      // Reset state: grants forced off, counters clear.
      @(negedge clk);
      chk("rst_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      chk("rst_if_stall", {31'd0, bus.if_stall}, 32'd1);
      chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
      chk("rst_conflict", {16'd0, bus.conflict_cnt}, 32'd0);
      tick();
      rst = 1'b1;

      // Fetch only, three consecutive words.
      bus.if_addr = 32'h0; ifq.push_back(mk(1'b1, 32'h13));
      @(negedge clk);
      chk("f1_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      chk("f1_if_stall", {31'd0, bus.if_stall}, 32'd0);
      chk("f1_mem_addr", {21'd0, bus.mem_addr}, 32'h0);
      tick();
      bus.if_addr = 32'h4; ifq.push_back(mk(1'b1, 32'h11));
      @(negedge clk);
      chk("f2_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      chk("f2_if_stall", {31'd0, bus.if_stall}, 32'd0);
      tick();
      bus.if_addr = 32'h8; ifq.push_back(mk(1'b1, 32'h22));
      @(negedge clk);
      chk("f3_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      chk("f3_mem_addr", {21'd0, bus.mem_addr}, 32'h2);
      tick();
      bus.if_req = 1'b0;
      tick();

      // Simultaneous fetch and load: data first, then fetch.
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
      dq.push_back(mk(1'b1, 32'hCAFE_0100));
      ifq.push_back(mk(1'b1, 32'h1111_0040));
      @(negedge clk);
      chk("c1_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
      chk("c1_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      chk("c1_if_stall", {31'd0, bus.if_stall}, 32'd1);
      chk("c1_mem_addr", {21'd0, bus.mem_addr}, 32'h40);
      chk("c1_mem_we", {31'd0, bus.mem_we}, 32'd0);
      tick();
      bus.d_req = 1'b0;
      @(negedge clk);
      chk("c2_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      chk("c2_mem_addr", {21'd0, bus.mem_addr}, 32'h10);
      chk("c2_conflict", {16'd0, bus.conflict_cnt}, 32'd1);
      tick();
      bus.if_req = 1'b0;
      tick();

      // Starvation bound: both held, fetch wins every fifth cycle.
      bus.if_req = 1'b1; bus.if_addr = 32'h300;
      bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
      for (int i = 0; i < 10; i++) begin
         logic exp_if;
         exp_if = (i == 4) || (i == 9);
         if (exp_if) ifq.push_back(mk(1'b1, 32'hA000_00C0));
         else        dq.push_back(mk(1'b1, 32'hA000_0080));
         @(negedge clk);
         chk($sformatf("s%0d_if_gnt", i), {31'd0, bus.if_gnt}, {31'd0, exp_if});
         chk($sformatf("s%0d_d_gnt", i), {31'd0, bus.d_gnt}, {31'd0, !exp_if});
         tick();
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      @(negedge clk);
      chk("s_conflict", {16'd0, bus.conflict_cnt}, 32'd11);
      tick();

      // Out-of-range store is dropped, load returns zero.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000_0000; bus.d_wdata = 32'hFFFF;
      dq.push_back(mk(1'b1, 32'h0));
      @(negedge clk);
      chk("o1_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
      chk("o1_mem_en", {31'd0, bus.mem_en}, 32'd0);
      chk("o1_mem_we", {31'd0, bus.mem_we}, 32'd0);
      tick();
      bus.d_we = 1'b0;
      dq.push_back(mk(1'b1, 32'h0));
      @(negedge clk);
      chk("o2_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
      chk("o2_mem_en", {31'd0, bus.mem_en}, 32'd0);
      tick();
      bus.d_req = 1'b0;
      tick();

      // Store then load at the top word of memory.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1FFC; bus.d_wdata = 32'hDEAD_BEEF;
      dq.push_back(mk(1'b0, 32'h0));
      @(negedge clk);
      chk("w1_mem_en", {31'd0, bus.mem_en}, 32'd1);
      chk("w1_mem_we", {31'd0, bus.mem_we}, 32'd1);
      chk("w1_mem_addr", {21'd0, bus.mem_addr}, 32'h7FF);
      chk("w1_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      tick();
      bus.d_we = 1'b0;
      dq.push_back(mk(1'b1, 32'hDEAD_BEEF));
      @(negedge clk);
      chk("w2_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("w2_mem_en", {31'd0, bus.mem_en}, 32'd1);
      tick();
      bus.d_req = 1'b0;
      repeat (2) tick();

      // Reset right after a data grant discards its response.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0;
      @(negedge clk);
      chk("r0_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
      tick();
      rst = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 32'h4;
      repeat (2) begin
         @(negedge clk);
         chk("r_d_valid", {31'd0, bus.d_valid}, 32'd0);
         chk("r_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
         chk("r_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
         chk("r_conflict", {16'd0, bus.conflict_cnt}, 32'd0);
         tick();
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic exp_if;
         exp_if = (i == 4);
         if (exp_if) ifq.push_back(mk(1'b1, 32'h11));
         else        dq.push_back(mk(1'b1, 32'h13));
         @(negedge clk);
         chk($sformatf("a%0d_if_gnt", i), {31'd0, bus.if_gnt}, {31'd0, exp_if});
         chk($sformatf("a%0d_d_gnt", i), {31'd0, bus.d_gnt}, {31'd0, !exp_if});
         tick();
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      @(negedge clk);
      chk("a_conflict", {16'd0, bus.conflict_cnt}, 32'd5);

      repeat (3) tick();
      chk("drain_ifq", ifq.size(), 32'd0);
      chk("drain_dq", dq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
